// File: rtl/instr_fetch.sv
// Instruction fetch unit: a single outstanding imem read at a time feeds a small FIFO
// that presents {pc, instr} to decode; a redirect flushes the FIFO and restarts fetch.
module instr_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] fetch_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] fifo_instr [DEPTH];
   logic [ADDR_W-1:0] fifo_pc [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;

   logic              push;
   logic              pop;
   logic [PTR_W:0]    count_next;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [ADDR_W-1:0] pc_inc;

   // A redirect cancels both the push of a same-cycle response and the decode pop.
   assign push             = (state == WAIT) && imem_rvalid && !redirect_valid;
   assign pop              = (count != '0) && if_ready && !redirect_valid;
   assign count_next       = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc           = pc_q + ADDR_W'(4);

   assign imem_addr = pc_q;
   assign fetch_pc  = pc_q;
   assign if_valid  = (count != '0);
   assign if_instr  = fifo_instr[rd_ptr];
   assign if_pc     = fifo_pc[rd_ptr];

   // pc_q is the address of the outstanding (or next) request; it only advances once the data lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         imem_req <= 1'b0;
         pc_q     <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= redirect_aligned;
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               state    <= imem_gnt ? DROP : REQ;
               imem_req <= !imem_gnt;
            end
            default: begin
               state    <= imem_rvalid ? REQ : DROP;
               imem_req <= imem_rvalid;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (count < FULL) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            REQ: begin
               if (imem_gnt) begin
                  state    <= WAIT;
                  imem_req <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  pc_q     <= pc_inc;
                  state    <= (count_next < FULL) ? REQ : IDLE;
                  imem_req <= (count_next < FULL);
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   // Storage is cleared on reset so the head reads as zero until the first word arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc_q;
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural instruction memory plus a scoreboard of the
// {pc, instr} pairs decode should see, with directed and random redirect/backpressure phases.
module tb_instr_fetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready = 1'b0;
   logic [31:0] fetch_pc;

   int check_cnt = 0;
   int err_cnt = 0;

   logic [63:0] exp_q[$];
   logic [63:0] sb_entry;
   logic [31:0] exp_addr = RESET_PC;
   logic [31:0] pend_addr = '0;
   logic        pend = 1'b0;
   logic        pend_drop = 1'b0;
   logic        accepted;
   int          pend_cnt = 0;
   int          mem_lat = 1;
   int          gnt_pct = 100;
   bit          rand_lat = 1'b0;
   bit          gnt_hold = 1'b0;
   int          accept_cnt = 0;

   instr_fetch #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH(DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .if_valid(if_valid),
      .if_instr(if_instr),
      .if_pc(if_pc),
      .if_ready(if_ready),
      .fetch_pc(fetch_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if_ready       = rdy;
   endtask

   task automatic resetDut(input logic rdy);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      if_ready       = rdy;
      repeat (2) @(posedge clk);
      accept_cnt = 0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitForValid(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (if_valid) break;
      end
      checkOutput(tag, 64'(if_valid), 64'd1);
   endtask

   // Memory model and decode-side scoreboard, evaluated mid-cycle so DUT outputs are settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pend        = 1'b0;
         pend_drop   = 1'b0;
         exp_addr    = RESET_PC;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
      end else begin
         if (if_valid && if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_valid", 64'(if_valid), 64'd0);
            end else begin
               sb_entry = exp_q.pop_front();
               checkOutput("sb_pc", 64'(if_pc), 64'(sb_entry[63:32]));
               checkOutput("sb_instr", 64'(if_instr), 64'(sb_entry[31:0]));
            end
         end
         imem_rvalid = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_data(pend_addr);
               pend        = 1'b0;
               if (!pend_drop && !redirect_valid) exp_q.push_back({pend_addr, mem_data(pend_addr)});
            end else begin
               pend_cnt--;
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            if (pend) pend_drop = 1'b1;
         end
         imem_gnt = !gnt_hold && ($urandom_range(99) < gnt_pct);
         accepted = imem_req && imem_gnt;
         if (accepted) begin
            checkOutput("imem_addr", 64'(imem_addr), 64'(exp_addr));
            checkOutput("one_outstanding", 64'(pend), 64'd0);
            accept_cnt++;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_drop = redirect_valid;
            pend_cnt  = rand_lat ? int'($urandom_range(3, 1)) : mem_lat;
         end
         if (redirect_valid) exp_addr = redirect_pc & 32'hFFFF_FFFC;
         else if (accepted) exp_addr = exp_addr + 32'd4;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset values, then streaming with a zero-wait memory.
      if_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst_req", 64'(imem_req), 64'd0);
      checkOutput("rst_addr", 64'(imem_addr), 64'(RESET_PC));
      checkOutput("rst_valid", 64'(if_valid), 64'd0);
      checkOutput("rst_instr", 64'(if_instr), 64'd0);
      checkOutput("rst_pc", 64'(if_pc), 64'd0);
      checkOutput("rst_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));
      @(posedge clk);
      accept_cnt = 0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("req_before_edge", 64'(imem_req), 64'd0);
      @(negedge clk);
      checkOutput("req_first_edge", 64'(imem_req), 64'd1);
      @(negedge clk);
      checkOutput("req_in_wait", 64'(imem_req), 64'd0);
      checkOutput("valid_early", 64'(if_valid), 64'd0);
      @(negedge clk);
      checkOutput("first_valid", 64'(if_valid), 64'd1);
      checkOutput("first_pc", 64'(if_pc), 64'(RESET_PC));
      checkOutput("first_instr", 64'(if_instr), 64'(mem_data(RESET_PC)));
      repeat (16) @(negedge clk);
      #1;
      checkOutput("stream_rate", 64'(accept_cnt), 64'd10);

      // Backpressure: decode stalled, only DEPTH words may be fetched.
      resetDut(1'b0);
      repeat (12) @(negedge clk);
      #1;
      checkOutput("bp_accepts", 64'(accept_cnt), 64'(DEPTH));
      checkOutput("bp_valid", 64'(if_valid), 64'd1);
      checkOutput("bp_head_pc", 64'(if_pc), 64'd0);
      checkOutput("bp_fetch_pc", 64'(fetch_pc), 64'd8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bp_req_idle", 64'(imem_req), 64'd0);
         checkOutput("bp_head_hold", 64'(if_instr), 64'(mem_data(32'd0)));
      end
      applyStimulus(1'b0, 32'd0, 1'b1);
      repeat (10) @(negedge clk);
      #1;
      checkOutput("bp_resume", 64'(accept_cnt >= 3), 64'd1);

      // Redirect while the request to 0x10 is outstanding.
      mem_lat = 3;
      resetDut(1'b1);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h10) break;
      end
      checkOutput("wait_target_addr", 64'(imem_addr), 64'h10);
      applyStimulus(1'b1, 32'h103, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("rdw_fetch_pc", 64'(fetch_pc), 64'h100);
      checkOutput("rdw_flush", 64'(if_valid), 64'd0);
      checkOutput("rdw_req_drop", 64'(imem_req), 64'd0);
      waitForValid("rdw_valid");
      checkOutput("rdw_first_pc", 64'(if_pc), 64'h100);

      // Redirect in the same cycle as a grant.
      mem_lat  = 1;
      gnt_hold = 1'b1;
      resetDut(1'b1);
      repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("req_held", 64'(imem_req), 64'd1);
      checkOutput("addr_held", 64'(imem_addr), 64'(RESET_PC));
      applyStimulus(1'b1, 32'h200, 1'b1);
      gnt_hold = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("rdg_req_drop", 64'(imem_req), 64'd0);
      checkOutput("rdg_fetch_pc", 64'(fetch_pc), 64'h200);
      waitForValid("rdg_valid");
      checkOutput("rdg_first_pc", 64'(if_pc), 64'h200);
      checkOutput("rdg_first_instr", 64'(if_instr), 64'(mem_data(32'h200)));

      // Redirect in the same cycle as rvalid.
      mem_lat = 2;
      resetDut(1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req) break;
      end
      applyStimulus(1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 32'h300, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("rdr_no_push", 64'(if_valid), 64'd0);
      checkOutput("rdr_fetch_pc", 64'(fetch_pc), 64'h300);
      checkOutput("rdr_req", 64'(imem_req), 64'd1);
      waitForValid("rdr_valid");
      checkOutput("rdr_first_pc", 64'(if_pc), 64'h300);

      // Random grants, latencies, stalls and redirects against the scoreboard.
      rand_lat = 1'b1;
      gnt_pct  = 60;
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(19) == 0, $urandom, $urandom_range(3) != 0);
      end
      rand_lat = 1'b0;
      gnt_pct  = 100;

      // PC wrap, then asynchronous reset in the middle of a WAIT.
      mem_lat = 2;
      applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'd0) break;
      end
      checkOutput("wrap_req", 64'(imem_req), 64'd1);
      checkOutput("wrap_addr", 64'(imem_addr), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("wrap_head_valid", 64'(if_valid), 64'd1);
      checkOutput("wrap_head_pc", 64'(if_pc), 64'hFFFF_FFFC);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 64'(if_valid), 64'd0);
      checkOutput("arst_pc", 64'(if_pc), 64'd0);
      checkOutput("arst_instr", 64'(if_instr), 64'd0);
      checkOutput("arst_req", 64'(imem_req), 64'd0);
      checkOutput("arst_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));
      mem_lat = 1;
      resetDut(1'b1);
      waitForValid("restart_valid");
      checkOutput("restart_pc", 64'(if_pc), 64'(RESET_PC));

      gnt_hold = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("final_valid", 64'(if_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
